// File: rtl/acc_dump_pkg.sv
// Shared types for the accumulate-and-dump stage.
package acc_dump_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/acc_dump_add.sv
// Sample extension, accumulate add and wrap detection (purely combinational).
module acc_dump_add #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 tc_eff,
    input  logic                 first,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 wrap
);

    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   full_sum;

    always_comb begin
        ext      = tc_eff ? ACC_WIDTH'($signed(din)) : ACC_WIDTH'(din);
        full_sum = {1'b0, acc} + {1'b0, ext};
        sum      = full_sum[ACC_WIDTH-1:0];
        wrap     = 1'b0;
        if (first) begin
            sum = ext;
        end else if (tc_eff) begin
            // Signed overflow: like-signed operands producing a result of the other sign.
            wrap = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                   (full_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        end else begin
            wrap = full_sum[ACC_WIDTH];
        end
    end

endmodule

// File: rtl/acc_dump.sv
// Accumulate LEN samples and hand each sum to the saturator over valid/ready.
// Optional synchronous partial-dump clear is enabled by defining ACC_DUMP_CLR_EN.
module acc_dump
    import acc_dump_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN       = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tc,
`ifdef ACC_DUMP_CLR_EN
    input  logic                 clr,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 tc_out,
    output logic                 wrap_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LEN - 1);

    out_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  tc_lat_q, tc_lat_d;
    logic                  wrap_acc_q, wrap_acc_d;
    logic [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
    logic                  tc_out_q, tc_out_d;
    logic                  wrap_out_q, wrap_out_d;

    logic                  clr_i;
    logic                  first;
    logic                  last;
    logic                  tc_eff;
    logic                  accept;
    logic                  dump;
    logic [ACC_WIDTH-1:0]  add_sum;
    logic                  add_wrap;

`ifdef ACC_DUMP_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == CNT_LAST);
    assign tc_eff    = first ? tc : tc_lat_q;
    assign out_valid = (state_q == FULL);
    // Only the sample that would complete a dump waits on a stalled output.
    assign in_ready  = !(last && out_valid && !out_ready);
    assign accept    = in_valid && in_ready && !clr_i;
    assign dump      = accept && last;

    acc_dump_add #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc    (acc_q),
        .din    (din),
        .tc_eff (tc_eff),
        .first  (first),
        .sum    (add_sum),
        .wrap   (add_wrap)
    );

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        tc_lat_d   = tc_lat_q;
        wrap_acc_d = wrap_acc_q;
        acc_out_d  = acc_out_q;
        tc_out_d   = tc_out_q;
        wrap_out_d = wrap_out_q;
        state_d    = state_q;

        if (clr_i) begin
            cnt_d      = '0;
            wrap_acc_d = 1'b0;
        end else if (accept) begin
            acc_d = add_sum;
            if (first) begin
                tc_lat_d = tc;
            end
            if (last) begin
                cnt_d      = '0;
                wrap_acc_d = 1'b0;
                acc_out_d  = add_sum;
                tc_out_d   = tc_eff;
                wrap_out_d = wrap_acc_q | add_wrap;
            end else begin
                cnt_d      = cnt_q + CNT_WIDTH'(1);
                wrap_acc_d = wrap_acc_q | add_wrap;
            end
        end

        case (state_q)
            EMPTY:   if (dump) state_d = FULL;
            FULL:    if (!dump && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            cnt_q      <= '0;
            acc_q      <= '0;
            tc_lat_q   <= 1'b0;
            wrap_acc_q <= 1'b0;
            acc_out_q  <= '0;
            tc_out_q   <= 1'b0;
            wrap_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            tc_lat_q   <= tc_lat_d;
            wrap_acc_q <= wrap_acc_d;
            acc_out_q  <= acc_out_d;
            tc_out_q   <= tc_out_d;
            wrap_out_q <= wrap_out_d;
        end
    end

    assign acc_out  = acc_out_q;
    assign tc_out   = tc_out_q;
    assign wrap_out = wrap_out_q;

endmodule
